// File: rtl/hazard_ctrl_if.sv
// Hazard-control port bundle between the ID/EX/MEM pipeline view and the hazard unit.
// HZD_PERF_CNT_EN adds the stallCnt/flushCnt performance counter outputs.
interface hazard_ctrl_if;
    logic       id_haveInstr;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_useRs;
    logic       id_useRt;
    logic       id_isBranch;
    logic       id_branchTaken;
    logic       id_isJump;
    logic       ex_memRead;
    logic       ex_regWrite;
    logic [4:0] ex_rd;
    logic       mem_memRead;
    logic [4:0] mem_rd;
    logic       pcWrite;
    logic       hzdWrite;
    logic       if_flush;
    logic       id_bubble;
    logic       stallState;
`ifdef HZD_PERF_CNT_EN
    logic [31:0] stallCnt;
    logic [31:0] flushCnt;
`endif

    // Pipeline side: drives the stage information, consumes the control outputs.
    modport master (
        output id_haveInstr, id_rs, id_rt, id_useRs, id_useRt,
        output id_isBranch, id_branchTaken, id_isJump,
        output ex_memRead, ex_regWrite, ex_rd, mem_memRead, mem_rd,
        input  pcWrite, hzdWrite, if_flush, id_bubble, stallState
`ifdef HZD_PERF_CNT_EN
        , input stallCnt, flushCnt
`endif
    );

    modport slave (
        input  id_haveInstr, id_rs, id_rt, id_useRs, id_useRt,
        input  id_isBranch, id_branchTaken, id_isJump,
        input  ex_memRead, ex_regWrite, ex_rd, mem_memRead, mem_rd,
        output pcWrite, hzdWrite, if_flush, id_bubble, stallState
`ifdef HZD_PERF_CNT_EN
        , output stallCnt, flushCnt
`endif
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Load-use / branch-operand hazard unit with IDLE/HOLD FSM, state updated on negedge clk.
// Optional HZD_PERF_CNT_EN adds wrapping stall and flush event counters.
module hazard_ctrl (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       match_ex;
    logic       match_mem;
    logic       lu;
    logic       br1;
    logic       br2;
    logic       stall;
    logic       redirect;

    // Register 0 never creates a dependency, even when a load targets it.
    assign match_ex  = hz.id_haveInstr && (hz.ex_rd != 5'd0) &&
                       ((hz.id_useRs && (hz.id_rs == hz.ex_rd)) ||
                        (hz.id_useRt && (hz.id_rt == hz.ex_rd)));
    assign match_mem = hz.id_haveInstr && (hz.mem_rd != 5'd0) &&
                       ((hz.id_useRs && (hz.id_rs == hz.mem_rd)) ||
                        (hz.id_useRt && (hz.id_rt == hz.mem_rd)));

    assign lu  = hz.ex_memRead && match_ex;
    assign br1 = hz.id_isBranch &&
                 ((hz.ex_regWrite && !hz.ex_memRead && match_ex) ||
                  (hz.mem_memRead && match_mem));
    assign br2 = hz.id_isBranch && hz.ex_memRead && match_ex;

    assign stall = !reset &&
                   ((state_q == HOLD) || ((state_q == IDLE) && (lu || br1 || br2)));

    assign redirect = hz.id_haveInstr &&
                      ((hz.id_isBranch && hz.id_branchTaken) || hz.id_isJump);

    always_comb begin
        state_d = IDLE;
        if (!reset && (state_q == IDLE) && br2) begin
            state_d = HOLD;
        end
    end

    always_ff @(negedge clk) begin
        state_q <= state_d;
    end

    // A redirect under stall is deferred: the branch stays in ID until the stall clears.
    assign hz.pcWrite    = !stall;
    assign hz.hzdWrite   = !stall;
    assign hz.id_bubble  = stall;
    assign hz.if_flush   = !reset && !stall && redirect;
    assign hz.stallState = !reset && (state_q == HOLD);

`ifdef HZD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(negedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (hz.if_flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign hz.stallCnt = stall_cnt_q;
    assign hz.flushCnt = flush_cnt_q;
`endif
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide ports: clk in 1, clock; all state updates on negedge clk, matching the pipeline registers.
REQ-002 SHALL provide ports: reset in 1, synchronous, active-high.
REQ-003 SHALL provide ports: id_haveInstr in 1, valid instruction in ID (from IF/ID); id_rs, id_rt in 5 each, ID source registers; id_useRs, id_useRt in 1 each, source actually read.
REQ-004 SHALL provide ports: id_isBranch in 1, beq/bne in ID; id_branchTaken in 1, branch resolved taken in ID; id_isJump in 1, j/jal/jr in ID.
REQ-005 SHALL provide ports: ex_memRead, ex_regWrite in 1 each; ex_rd in 5, EX destination register; mem_memRead in 1; mem_rd in 5, MEM destination register.
REQ-006 SHALL provide ports: pcWrite out 1, PC update enable; hzdWrite out 1, IF/ID write enable (0 = hold); if_flush out 1, IF/ID zero-load; id_bubble out 1, zero ID/EX control fields; stallState out 1, 1 = HOLD.

Function
REQ-007 SHALL define match(r) = (r != 0) && ((id_useRs && id_rs == r) || (id_useRt && id_rt == r)), evaluated only when id_haveInstr = 1; otherwise all hazards are 0.
REQ-008 SHALL flag load-use hazard LU = ex_memRead && match(ex_rd): a 1-cycle stall.
REQ-009 SHALL flag BR1 = id_isBranch && ((ex_regWrite && !ex_memRead && match(ex_rd)) || (mem_memRead && match(mem_rd))): a 1-cycle stall.
REQ-010 SHALL flag BR2 = id_isBranch && ex_memRead && match(ex_rd): a 2-cycle stall; BR2 takes precedence over LU.
REQ-011 SHALL implement FSM states IDLE and HOLD; reset state IDLE.
REQ-012 SHALL assert stall in IDLE combinationally when LU, BR1 or BR2 holds; stall in HOLD unconditionally.
REQ-013 SHALL transition IDLE->HOLD at negedge when BR2; HOLD->IDLE at the next negedge unconditionally; otherwise remain in IDLE.
REQ-014 SHALL drive pcWrite = hzdWrite = !stall, id_bubble = stall.
REQ-015 SHALL drive if_flush = !stall && id_haveInstr && ((id_isBranch && id_branchTaken) || id_isJump).
REQ-016 SHALL suppress flush on a simultaneous stall and taken branch/jump; the flush occurs in the first non-stall cycle, because the branch remains in ID.
REQ-017 SHALL keep hzdWrite = 1 whenever if_flush = 1, so the IF/ID register loads zeros.
REQ-018 SHALL treat register 0 as never hazardous, including for a load into $zero.
REQ-019 SHALL have zero-cycle latency: all outputs are combinational from the current inputs and state; only the state (and counters) are registered.

Reset
REQ-020 SHALL, while reset = 1, force state IDLE and drive pcWrite = 1, hzdWrite = 1, if_flush = 0, id_bubble = 0, stallState = 0, independent of other inputs.
REQ-021 SHALL have reset asserted in HOLD return the block to IDLE at that negedge, discarding the remaining stall cycle.
REQ-022 SHALL, after reset deasserts, evaluate hazards on the first cycle with no residual state.

Configuration
REQ-023 SHALL, with HZD_PERF_CNT_EN defined, add outputs stallCnt out 32 and flushCnt out 32.
REQ-024 SHALL, with HZD_PERF_CNT_EN defined, increment stallCnt on each negedge where stall = 1 and increment flushCnt on each negedge where if_flush = 1.
REQ-025 SHALL, with HZD_PERF_CNT_EN defined, make both counters wrap modulo 2^32 and clear them on reset.
REQ-026 SHALL, without HZD_PERF_CNT_EN, omit the counter ports and registers entirely, with all other behaviour identical.

Verification
REQ-027 SHALL cover load-use: ex_memRead=1, ex_rd=8, id_rs=8, id_useRs=1 -> one cycle of hzdWrite=0, pcWrite=0, id_bubble=1, then all return to normal.
REQ-028 SHALL cover branch after load: id_isBranch=1, ex_memRead=1, ex_rd=9=id_rt, id_useRt=1 -> two stall cycles, with stallState=1 on the second, then IDLE.
REQ-029 SHALL cover a taken branch with no hazard: id_isBranch=1, id_branchTaken=1 -> if_flush=1, hzdWrite=1 for one cycle; id_isJump=1 gives the same result.
REQ-030 SHALL cover stall plus taken branch: BR1 via ex_regWrite, ex_rd=5 -> if_flush=0 during the stall and if_flush=1 on the following cycle.
REQ-031 SHALL cover $zero and an empty ID: ex_rd=0 or id_haveInstr=0 with matching registers -> no stall and no flush.
REQ-032 SHALL cover reset mid-HOLD -> IDLE on that negedge with reset outputs; with HZD_PERF_CNT_EN, stallCnt=0 and flushCnt=0.
